// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers, decode and the register-file write arbiter.
// master: producers/decode/register file side; slave: regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  s0_valid;
  logic                  s0_ready;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s1_valid;
  logic                  s1_ready;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_sel_1;
  logic [ADDR_WIDTH-1:0] read_sel_2;
  logic                  pend_1;
  logic                  pend_2;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output read_sel_1, read_sel_2,
    input  s0_ready, s1_ready,
    input  RegWrite, write_address, write_data,
    input  pend_1, pend_2
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  read_sel_1, read_sel_2,
    output s0_ready, s1_ready,
    output RegWrite, write_address, write_data,
    output pend_1, pend_2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (src0) and load (src1) FIFOs.
// Optional macro WB_PENDING_CHECK_EN enables the combinational in-flight write check (pend_1/pend_2).
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem     [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr  [2];
  logic [PTR_W-1:0] rd_ptr  [2];
  logic [CNT_W-1:0] count   [2];
  entry_t           in_entry[2];
  logic [1:0]       full;
  logic [1:0]       not_empty;
  logic [1:0]       push;
  logic [1:0]       pop;

  logic                  last_grant;
  logic                  grant_valid;
  logic                  grant_src;
  entry_t                head;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;

  // FIFO status comes from registered counts only, so a same-cycle pop never raises ready
  always_comb begin
    in_entry[0] = '{addr: bus.s0_addr, data: bus.s0_data};
    in_entry[1] = '{addr: bus.s1_addr, data: bus.s1_data};
    for (int i = 0; i < 2; i++) begin
      full[i]      = (count[i] == CNT_W'(DEPTH));
      not_empty[i] = (count[i] != '0);
    end
    push[0] = bus.s0_valid & ~full[0];
    push[1] = bus.s1_valid & ~full[1];
  end

  assign bus.s0_ready = ~full[0];
  assign bus.s1_ready = ~full[1];

  // Round-robin: on contention the source that did not win last time is granted
  always_comb begin
    grant_valid = |not_empty;
    grant_src   = 1'b0;
    if (&not_empty) begin
      grant_src = ~last_grant;
    end else begin
      grant_src = ~not_empty[0];
    end
    pop = '0;
    if (grant_valid) begin
      pop[grant_src] = 1'b1;
    end
    head = mem[grant_src][rd_ptr[grant_src]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_entry[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // r0 entries are still granted (and advance round-robin) but never assert the write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write     <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      last_grant    <= 1'b1;
    end else begin
      reg_write <= grant_valid && (head.addr != '0);
      if (grant_valid) begin
        write_address <= head.addr;
        write_data    <= head.data;
        last_grant    <= grant_src;
      end
    end
  end

  assign bus.RegWrite      = reg_write;
  assign bus.write_address = write_address;
  assign bus.write_data    = write_data;

`ifdef WB_PENDING_CHECK_EN
  logic [DEPTH-1:0] live [2];
  logic             pend_1;
  logic             pend_2;

  // An entry slot is live when its distance from the read pointer is below the count
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        live[i][j] = CNT_W'(PTR_W'(PTR_W'(j) - rd_ptr[i])) < count[i];
      end
    end
  end

  always_comb begin
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (live[i][j] && (mem[i][j].addr == bus.read_sel_1)) pend_1 = 1'b1;
        if (live[i][j] && (mem[i][j].addr == bus.read_sel_2)) pend_2 = 1'b1;
      end
    end
    if (reg_write && (write_address == bus.read_sel_1)) pend_1 = 1'b1;
    if (reg_write && (write_address == bus.read_sel_2)) pend_2 = 1'b1;
    if (bus.read_sel_1 == '0) pend_1 = 1'b0;
    if (bus.read_sel_2 == '0) pend_2 = 1'b0;
  end

  assign bus.pend_1 = pend_1;
  assign bus.pend_2 = pend_2;
`else
  assign bus.pend_1 = 1'b0;
  assign bus.pend_2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-level reference model, random and directed traffic.
module tb_regfile_wb_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  wr_t stim0[$], stim1[$];
  wr_t mq0[$], mq1[$];
  wr_t expq[$];
  wr_t observed[$];
  int  last_grant = 1;
  bit  exp_we = 1'b0;
  wr_t exp_out = '0;
  bit  gaps = 1'b0;
  bit  rand_sel = 1'b0;
  int  checks = 0;
  int  passed = 0;
  int  ready0_low = 0;
  int  pend1_cnt = 0;
  int  pend2_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit pend_model(input logic [AW-1:0] sel);
`ifdef WB_PENDING_CHECK_EN
    if (sel == '0) return 1'b0;
    foreach (mq0[i]) if (mq0[i].addr == sel) return 1'b1;
    foreach (mq1[i]) if (mq1[i].addr == sel) return 1'b1;
    if (exp_we && exp_out.addr == sel) return 1'b1;
    return 1'b0;
`else
    return sel != sel;
`endif
  endfunction

  // Producers: present queued stimulus, optionally with random idle cycles
  always @(negedge clk) begin
    bus.s0_valid = (stim0.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    bus.s1_valid = (stim1.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    if (stim0.size() > 0) {bus.s0_addr, bus.s0_data} = stim0[0];
    if (stim1.size() > 0) {bus.s1_addr, bus.s1_data} = stim1[0];
    if (rand_sel) begin
      bus.read_sel_1 = AW'($urandom_range(0, 31));
      bus.read_sel_2 = AW'($urandom_range(0, 31));
    end
  end

  // Reference model: two bounded queues drained one entry per cycle, alternating on contention
  always @(posedge clk) begin
    bit  rdy0, rdy1;
    int  src;
    wr_t e;
    if (rst_n) begin
      rdy0 = mq0.size() < DEPTH;
      rdy1 = mq1.size() < DEPTH;
      if (mq0.size() > 0 && mq1.size() > 0) src = (last_grant == 0) ? 1 : 0;
      else if (mq0.size() > 0)              src = 0;
      else if (mq1.size() > 0)              src = 1;
      else                                  src = -1;
      exp_we = 1'b0;
      if (src >= 0) begin
        if (src == 0) e = mq0.pop_front();
        else          e = mq1.pop_front();
        last_grant = src;
        if (e.addr != '0) begin
          exp_we  = 1'b1;
          exp_out = e;
          expq.push_back(e);
        end
      end
      if (bus.s0_valid && rdy0) begin
        mq0.push_back(wr_t'{addr: bus.s0_addr, data: bus.s0_data});
        if (stim0.size() > 0) void'(stim0.pop_front());
      end
      if (bus.s1_valid && rdy1) begin
        mq1.push_back(wr_t'{addr: bus.s1_addr, data: bus.s1_data});
        if (stim1.size() > 0) void'(stim1.pop_front());
      end
    end
  end

  // Monitor: compare every presented write and the status outputs against the model
  always @(posedge clk) begin
    wr_t e;
    #3;
    if (rst_n) begin
      if (bus.RegWrite) begin
        if (expq.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check("write_address", 64'(bus.write_address), 64'(e.addr));
          check("write_data", 64'(bus.write_data), 64'(e.data));
        end
        observed.push_back(wr_t'{addr: bus.write_address, data: bus.write_data});
      end
      check("regwrite", 64'(bus.RegWrite), 64'(exp_we));
      check("s0_ready", 64'(bus.s0_ready), 64'(mq0.size() < DEPTH));
      check("s1_ready", 64'(bus.s1_ready), 64'(mq1.size() < DEPTH));
      check("pend_1", 64'(bus.pend_1), 64'(pend_model(bus.read_sel_1)));
      check("pend_2", 64'(bus.pend_2), 64'(pend_model(bus.read_sel_2)));
      if (!bus.s0_ready) ready0_low++;
      if (bus.pend_1) pend1_cnt++;
      if (bus.pend_2) pend2_cnt++;
    end
  end

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #4;
      if (stim0.size() == 0 && stim1.size() == 0 && mq0.size() == 0 &&
          mq1.size() == 0 && expq.size() == 0 && !bus.RegWrite) return;
    end
    check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stim0.delete(); stim1.delete();
    mq0.delete(); mq1.delete(); expq.delete();
    exp_we = 1'b0; exp_out = '0; last_grant = 1;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    #1;
    check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    check("rst_write_address", 64'(bus.write_address), 64'd0);
    check("rst_write_data", 64'(bus.write_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    check("rst_s0_ready", 64'(bus.s0_ready), 64'd1);
    check("rst_s1_ready", 64'(bus.s1_ready), 64'd1);
  endtask

  initial begin
    int unsigned exp_order[8];
    exp_order = '{1, 9, 2, 10, 3, 11, 4, 12};
    bus.s0_valid = 1'b0; bus.s0_addr = '0; bus.s0_data = '0;
    bus.s1_valid = 1'b0; bus.s1_addr = '0; bus.s1_data = '0;
    bus.read_sel_1 = '0; bus.read_sel_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #4;

    // Continuous contention straight out of reset
    observed.delete();
    ready0_low = 0;
    for (int k = 0; k < 4; k++) begin
      stim0.push_back(wr_t'{addr: AW'(k + 1), data: $urandom});
      stim1.push_back(wr_t'{addr: AW'(k + 9), data: $urandom});
    end
    wait_drain(100);
    check("contention_count", 64'(observed.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      if (k < observed.size()) check("contention_order", 64'(observed[k].addr), 64'(exp_order[k]));
    check("s0_ready_seen_low", 64'(ready0_low > 0), 64'd1);

    // Single src0 write
    observed.delete();
    stim0.push_back(wr_t'{addr: AW'(5), data: 32'hDEADBEEF});
    wait_drain(50);
    check("single_count", 64'(observed.size()), 64'd1);
    if (observed.size() > 0) begin
      check("single_addr", 64'(observed[0].addr), 64'd5);
      check("single_data", 64'(observed[0].data), 64'hDEADBEEF);
    end

    // r0 write from src1 is consumed silently; next contention goes to src0
    observed.delete();
    stim1.push_back(wr_t'{addr: AW'(0), data: $urandom});
    wait_drain(50);
    check("r0_no_write", 64'(observed.size()), 64'd0);
    stim0.push_back(wr_t'{addr: AW'(3), data: $urandom});
    stim1.push_back(wr_t'{addr: AW'(4), data: $urandom});
    wait_drain(50);
    check("after_r0_count", 64'(observed.size()), 64'd2);
    if (observed.size() == 2) begin
      check("after_r0_first", 64'(observed[0].addr), 64'd3);
      check("after_r0_second", 64'(observed[1].addr), 64'd4);
    end

    // In-flight write to r7 seen by read_sel_1; read_sel_2 = r0 never pending
    bus.read_sel_1 = AW'(7);
    bus.read_sel_2 = AW'(0);
    pend1_cnt = 0;
    pend2_cnt = 0;
    stim0.push_back(wr_t'{addr: AW'(7), data: $urandom});
    wait_drain(50);
`ifdef WB_PENDING_CHECK_EN
    check("pend1_cycles", 64'(pend1_cnt), 64'd2);
`else
    check("pend1_cycles", 64'(pend1_cnt), 64'd0);
`endif
    check("pend2_cycles", 64'(pend2_cnt), 64'd0);

    // Random traffic, reset mid-burst, then more random traffic
    gaps = 1'b1;
    rand_sel = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #4;
        if (stim0.size() < 3 && $urandom_range(0, 1) != 0)
          stim0.push_back(wr_t'{addr: AW'($urandom_range(0, 31)), data: $urandom});
        if (stim1.size() < 3 && $urandom_range(0, 1) != 0)
          stim1.push_back(wr_t'{addr: AW'($urandom_range(0, 31)), data: $urandom});
      end
      if (phase == 0) do_reset();
    end
    wait_drain(200);
    check("final_expq_empty", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
